// File: rtl/timer_pkg.sv
// Shared types for the anti-theft countdown timer: FSM state encoding and
// the meaning of each programmable interval slot.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    localparam int SLOT_ARM       = 0;
    localparam int SLOT_DRIVER    = 1;
    localparam int SLOT_PASSENGER = 2;
    localparam int SLOT_ALARM     = 3;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..CLK_HZ-1 prescaler producing one-cycle 1 Hz and 2 Hz
// enables; clear restarts the count so a fresh countdown gets a full second.
module tick_prescaler #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic one_hz_enable,
    output logic two_hz_enable
);

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2 - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gated by reset so that CLK_HZ=2 (HALF==0) stays quiet while held.
    assign one_hz_enable = reset && (cnt_q == LAST);
    assign two_hz_enable = reset && ((cnt_q == HALF) || (cnt_q == LAST));

endmodule

// File: rtl/prog_countdown_timer.sv
// Reprogrammable interval bank plus seconds countdown FSM sitting between the
// anti-theft controller and the display/siren logic.
module prog_countdown_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int N_PARAM = 4,
    parameter int VAL_W   = 4,
    parameter int SEL_W   = (N_PARAM > 1) ? $clog2(N_PARAM) : 1,
    parameter logic [N_PARAM*VAL_W-1:0] DEFAULTS = {4'd10, 4'd15, 4'd8, 4'd6}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             reprogram,
    input  logic [SEL_W-1:0] prog_sel,
    input  logic [VAL_W-1:0] prog_value,
    input  logic [SEL_W-1:0] interval_sel,
    input  logic             start_timer,
    input  logic             cancel,
    output logic             expired,
    output logic             busy,
    output logic [VAL_W-1:0] counter,
    output logic             one_hz_enable,
    output logic             two_hz_enable
);

    state_t                          state_q, state_d;
    logic [VAL_W-1:0]                counter_q, counter_d;
    logic [N_PARAM-1:0][VAL_W-1:0]   bank_q, bank_d;
    logic [VAL_W-1:0]                load_val;

    tick_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_tick (
        .clock        (clock),
        .reset        (reset),
        .clear        (start_timer),
        .one_hz_enable(one_hz_enable),
        .two_hz_enable(two_hz_enable)
    );

    // Start reads the registered bank, so a same-cycle write is not yet visible.
    always_comb begin
        load_val = '0;
        if (int'(interval_sel) < N_PARAM) begin
            load_val = bank_q[interval_sel];
        end
    end

    always_comb begin
        bank_d = bank_q;
        if (reprogram && int'(prog_sel) < N_PARAM) begin
            bank_d[prog_sel] = prog_value;
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        case (state_q)
            RUN: begin
                if (cancel) begin
                    state_d   = IDLE;
                    counter_d = '0;
                end else if (start_timer) begin
                    counter_d = load_val;
                    state_d   = (load_val == '0) ? EXPIRE : RUN;
                end else if (one_hz_enable) begin
                    if (counter_q <= VAL_W'(1)) begin
                        counter_d = '0;
                        state_d   = EXPIRE;
                    end else begin
                        counter_d = counter_q - 1'b1;
                    end
                end
            end
            default: begin
                // IDLE and EXPIRE both accept a new start; EXPIRE otherwise falls back to IDLE.
                state_d   = IDLE;
                counter_d = '0;
                if (start_timer && !cancel) begin
                    counter_d = load_val;
                    state_d   = (load_val == '0) ? EXPIRE : RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            bank_q    <= DEFAULTS;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            bank_q    <= bank_d;
        end
    end

    assign expired = (state_q == EXPIRE);
    assign busy    = (state_q == RUN);
    assign counter = counter_q;

endmodule

// File: tb/tb_prog_countdown_timer.sv
// Directed bench for prog_countdown_timer at CLK_HZ=8 with default slots.
module tb_prog_countdown_timer;
    import timer_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       reprogram = 1'b0;
    logic [1:0] prog_sel = '0;
    logic [3:0] prog_value = '0;
    logic [1:0] interval_sel = '0;
    logic       start_timer = 1'b0;
    logic       cancel = 1'b0;
    logic       expired, busy, one_hz_enable, two_hz_enable;
    logic [3:0] counter;

    int n_tests = 0;
    int n_fail  = 0;

    prog_countdown_timer #(
        .CLK_HZ(8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .reprogram    (reprogram),
        .prog_sel     (prog_sel),
        .prog_value   (prog_value),
        .interval_sel (interval_sel),
        .start_timer  (start_timer),
        .cancel       (cancel),
        .expired      (expired),
        .busy         (busy),
        .counter      (counter),
        .one_hz_enable(one_hz_enable),
        .two_hz_enable(two_hz_enable)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_start(input int sel);
        interval_sel = 2'(sel);
        start_timer  = 1'b1;
        tick();
        start_timer  = 1'b0;
    endtask

    task automatic do_prog(input int sel, input int val);
        prog_sel   = 2'(sel);
        prog_value = 4'(val);
        reprogram  = 1'b1;
        tick();
        reprogram  = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    initial begin
        int seen;

        // Reset held
        #12;
        chk("rst_counter", counter, 0);
        chk("rst_busy", busy, 0);
        chk("rst_expired", expired, 0);
        chk("rst_one_hz", one_hz_enable, 0);
        chk("rst_two_hz", two_hz_enable, 0);
        reset = 1'b1;

        // Free-running enables after release
        for (int n = 1; n <= 16; n++) begin
            tick();
            chk($sformatf("one_hz_n%0d", n), one_hz_enable, (n % 8 == 7) ? 1 : 0);
            chk($sformatf("two_hz_n%0d", n), two_hz_enable, (n % 4 == 3) ? 1 : 0);
        end
        chk("idle_busy", busy, 0);
        chk("idle_counter", counter, 0);

        // Arm slot: 6 seconds
        do_start(SLOT_ARM);
        chk("arm_load", counter, 6);
        chk("arm_busy", busy, 1);
        tick(7);
        chk("arm_k7", counter, 6);
        for (int s = 5; s >= 1; s--) begin
            tick(s == 5 ? 1 : 8);
            chk($sformatf("arm_cnt%0d", s), counter, s);
        end
        tick(7);
        chk("arm_k47_exp", expired, 0);
        chk("arm_k47_cnt", counter, 1);
        tick();
        chk("arm_k48_exp", expired, 1);
        chk("arm_k48_cnt", counter, 0);
        chk("arm_k48_busy", busy, 0);
        tick();
        chk("arm_after_exp", expired, 0);
        chk("arm_after_busy", busy, 0);

        // Reprogram driver slot to 3
        do_prog(SLOT_DRIVER, 3);
        do_start(SLOT_DRIVER);
        chk("drv_load", counter, 3);
        tick(23);
        chk("drv_k23_cnt", counter, 1);
        chk("drv_k23_exp", expired, 0);
        tick();
        chk("drv_k24_exp", expired, 1);
        tick();
        do_start(SLOT_DRIVER);
        tick(5);
        reset = 1'b0;
        #1;
        chk("midrst_counter", counter, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_two_hz", two_hz_enable, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("postrst_idle", busy, 0);
        do_start(SLOT_DRIVER);
        chk("postrst_bank_default", counter, 8);
        do_cancel();

        // Passenger 15, retrigger to alarm 10 at counter 9
        do_start(SLOT_PASSENGER);
        chk("pas_load", counter, 15);
        tick(48);
        chk("pas_at9", counter, 9);
        do_start(SLOT_ALARM);
        chk("retrig_load", counter, 10);
        chk("retrig_busy", busy, 1);
        tick(7);
        chk("retrig_r7", counter, 10);
        tick();
        chk("retrig_r8", counter, 9);
        tick(71);
        chk("retrig_r79_cnt", counter, 1);
        chk("retrig_r79_exp", expired, 0);
        tick();
        chk("retrig_r80_exp", expired, 1);
        tick();

        // Cancel at counter 2
        do_start(SLOT_ARM);
        tick(32);
        chk("cxl_at2", counter, 2);
        do_cancel();
        chk("cxl_counter", counter, 0);
        chk("cxl_busy", busy, 0);
        chk("cxl_exp", expired, 0);
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (expired) seen++;
        end
        chk("cxl_no_expire", seen, 0);
        cancel = 1'b1;
        start_timer = 1'b1;
        interval_sel = 2'(SLOT_ARM);
        tick();
        cancel = 1'b0;
        start_timer = 1'b0;
        chk("cxl_start_busy", busy, 0);
        chk("cxl_start_cnt", counter, 0);
        chk("cxl_start_exp", expired, 0);

        // Zero-length interval and write/start collision
        do_prog(SLOT_ALARM, 0);
        do_start(SLOT_ALARM);
        chk("zero_exp", expired, 1);
        chk("zero_cnt", counter, 0);
        chk("zero_busy", busy, 0);
        tick();
        chk("zero_after", expired, 0);
        prog_sel = 2'(SLOT_ALARM);
        prog_value = 4'd15;
        reprogram = 1'b1;
        do_start(SLOT_ALARM);
        reprogram = 1'b0;
        chk("coll_old_val_exp", expired, 1);
        chk("coll_old_val_cnt", counter, 0);
        tick();
        do_start(SLOT_ALARM);
        chk("coll_new_val", counter, 15);
        chk("coll_new_busy", busy, 1);
        // Write during run does not disturb the countdown
        do_prog(SLOT_ALARM, 2);
        chk("wr_during_run", counter, 15);
        do_cancel();
        chk("final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
